// File: rtl/axi4_slave_ram_pkg.sv
// Shared constants, FSM state encodings and request-check helpers for the AXI4 slave RAM.
package axi4_slave_ram_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    WIDLE = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RIDLE = 1'b0,
    RDATA = 1'b1
  } rd_state_e;

  // Only full-width INCR bursts are served; anything else is answered with SLVERR.
  function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [2:0] full_size);
    req_err = (burst != AXI_BURST_INCR) || (size != full_size);
  endfunction

  function automatic logic [1:0] resp_code(input logic err);
    resp_code = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_slave_ram_array.sv
// Byte-enabled word array: one synchronous write port, one asynchronous read port, no reset.
module axi4_slave_ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte-lane write; lanes with a clear strobe keep their old contents
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave memory with independent single-outstanding read and write burst engines
// sharing one word-addressed array.
module axi4_slave_ram
  import axi4_slave_ram_pkg::*;
#(
  parameter int AXI4_DATA_W = 32,
  parameter int AXI4_ADD_W  = 10,
  parameter int AXI4_ID_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI4_ID_W-1:0]     awid,
  input  logic [AXI4_ADD_W-1:0]    awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [AXI4_DATA_W-1:0]   wdata,
  input  logic [AXI4_DATA_W/8-1:0] wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [AXI4_ID_W-1:0]     bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [AXI4_ID_W-1:0]     arid,
  input  logic [AXI4_ADD_W-1:0]    araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [AXI4_ID_W-1:0]     rid,
  output logic [AXI4_DATA_W-1:0]   rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int BYTES   = AXI4_DATA_W / 8;
  localparam int BYTES_W = $clog2(BYTES);
  localparam int WA      = AXI4_ADD_W - BYTES_W;
  localparam logic [2:0] SIZE_FULL = 3'(BYTES_W);

  // ---------------- write channel ----------------
  wr_state_e             wstate_r, wstate_nxt_s;
  logic [AXI4_ID_W-1:0]  wid_r;
  logic [WA-1:0]         waddr_r;
  logic [7:0]            wlen_r;
  logic [7:0]            wbeat_r;
  logic                  werr_r;
  logic                  awready_r, wready_r, bvalid_r;
  logic [AXI4_ID_W-1:0]  bid_r;
  logic [1:0]            bresp_r;
  logic                  aw_hs_s, w_hs_s, b_hs_s, wlen_err_s, mem_we_s;

  assign aw_hs_s    = awvalid && awready_r;
  assign w_hs_s     = wvalid && wready_r;
  assign b_hs_s     = bvalid_r && bready;
  // wlast must coincide exactly with the beat numbered awlen
  assign wlen_err_s = wlast != (wbeat_r == wlen_r);
  assign mem_we_s   = w_hs_s && !werr_r;

  // Write FSM next-state decode
  always_comb begin
    wstate_nxt_s = wstate_r;
    case (wstate_r)
      WIDLE: begin
        if (aw_hs_s) wstate_nxt_s = WDATA;
        else         wstate_nxt_s = WIDLE;
      end
      WDATA: begin
        if (w_hs_s && wlast) wstate_nxt_s = WRESP;
        else                 wstate_nxt_s = WDATA;
      end
      WRESP: begin
        if (b_hs_s) wstate_nxt_s = WIDLE;
        else        wstate_nxt_s = WRESP;
      end
      default: wstate_nxt_s = WIDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wstate_r <= WIDLE;
    else        wstate_r <= wstate_nxt_s;
  end

  // Write handshake outputs, burst context and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      wid_r     <= {AXI4_ID_W{1'b0}};
      waddr_r   <= {WA{1'b0}};
      wlen_r    <= 8'd0;
      wbeat_r   <= 8'd0;
      werr_r    <= 1'b0;
      bid_r     <= {AXI4_ID_W{1'b0}};
      bresp_r   <= 2'b00;
    end else begin
      awready_r <= (wstate_nxt_s == WIDLE);
      wready_r  <= (wstate_nxt_s == WDATA);
      bvalid_r  <= (wstate_nxt_s == WRESP);
      if (aw_hs_s) begin
        wid_r   <= awid;
        waddr_r <= awaddr[AXI4_ADD_W-1:BYTES_W];
        wlen_r  <= awlen;
        wbeat_r <= 8'd0;
        werr_r  <= req_err(awburst, awsize, SIZE_FULL);
      end else if (w_hs_s) begin
        waddr_r <= waddr_r + WA'(1);
        wbeat_r <= wbeat_r + 8'd1;
        werr_r  <= werr_r || wlen_err_s;
      end
      if (w_hs_s && wlast) begin
        bid_r   <= wid_r;
        bresp_r <= resp_code(werr_r || wlen_err_s);
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e             rstate_r, rstate_nxt_s;
  logic [AXI4_ID_W-1:0]  rid_r;
  logic [WA-1:0]         raddr_r;
  logic [7:0]            rlen_r;
  logic [7:0]            rbeat_r;
  logic                  rerr_r;
  logic                  arready_r, rvalid_r, rlast_r;
  logic [1:0]            rresp_r;
  logic                  ar_hs_s, r_hs_s, ar_err_s;
  logic [AXI4_DATA_W-1:0] mem_rd_s;

  assign ar_hs_s  = arvalid && arready_r;
  assign r_hs_s   = rvalid_r && rready;
  assign ar_err_s = req_err(arburst, arsize, SIZE_FULL);

  // Read FSM next-state decode
  always_comb begin
    rstate_nxt_s = rstate_r;
    case (rstate_r)
      RIDLE: begin
        if (ar_hs_s) rstate_nxt_s = RDATA;
        else         rstate_nxt_s = RIDLE;
      end
      RDATA: begin
        if (r_hs_s && rlast_r) rstate_nxt_s = RIDLE;
        else                   rstate_nxt_s = RDATA;
      end
      default: rstate_nxt_s = RIDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstate_r <= RIDLE;
    else        rstate_r <= rstate_nxt_s;
  end

  // Read handshake outputs, burst context and R payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {AXI4_ID_W{1'b0}};
      raddr_r   <= {WA{1'b0}};
      rlen_r    <= 8'd0;
      rbeat_r   <= 8'd0;
      rerr_r    <= 1'b0;
      rresp_r   <= 2'b00;
    end else begin
      arready_r <= (rstate_nxt_s == RIDLE);
      rvalid_r  <= (rstate_nxt_s == RDATA);
      if (ar_hs_s) begin
        rid_r   <= arid;
        raddr_r <= araddr[AXI4_ADD_W-1:BYTES_W];
        rlen_r  <= arlen;
        rbeat_r <= 8'd0;
        rerr_r  <= ar_err_s;
        rresp_r <= resp_code(ar_err_s);
        rlast_r <= (arlen == 8'd0);
      end else if (r_hs_s) begin
        raddr_r <= raddr_r + WA'(1);
        rbeat_r <= rbeat_r + 8'd1;
        // drops back to 0 after the final beat since rbeat+1 then exceeds rlen
        rlast_r <= ((rbeat_r + 8'd1) == rlen_r);
      end
    end
  end

  axi4_slave_ram_array #(
    .DATA_W (AXI4_DATA_W),
    .ADDR_W (WA)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (waddr_r),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (raddr_r),
    .rdata (mem_rd_s)
  );

  // Sub-word address bits carry no information for full-width beats
  if (BYTES_W > 0) begin : g_unused_addr
    logic unused_addr_s;
    assign unused_addr_s = ^{awaddr[BYTES_W-1:0], araddr[BYTES_W-1:0]};
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rlast   = rlast_r;
  assign rid     = rid_r;
  assign rresp   = rresp_r;
  assign rdata   = (rvalid_r && !rerr_r) ? mem_rd_s : {AXI4_DATA_W{1'b0}};

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Self-checking bench for axi4_slave_ram: table of write/read-back transactions plus
// hand-written wrap-read and mid-burst reset sequences, R beats checked from a scoreboard.
module tb_axi4_slave_ram;
  import axi4_slave_ram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int IW = 8;
  localparam int BY = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [BY-1:0] wstrb;

  always #5 clk = ~clk;

  axi4_slave_ram #(.AXI4_DATA_W(DW), .AXI4_ADD_W(AW), .AXI4_ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    resp;
    logic [IW-1:0] id;
  } rexp_t;

  typedef struct {
    logic [IW-1:0] id;
    int            addr;
    int            len;
    logic [1:0]    burst;
    logic [2:0]    size;
    logic [3:0]    strb;
    logic [DW-1:0] base;
    int            bhold;
    logic [1:0]    exp_b;
    logic          rd;
    int            rd_len;
    logic [2:0]    rd_size;
    logic [1:0]    exp_r;
    int            stall_beat;
    int            stall_cyc;
    logic          cflag;
    logic [DW-1:0] cval;
  } vec_t;

  int total = 0;
  int bad = 0;
  rexp_t sb[$];
  logic [DW-1:0] model [256];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input vec_t v);
    int n;
    int w;
    logic ok;
    logic [DW-1:0] d;
    ok = (v.burst == 2'b01) && (v.size == 3'd2);
    @(negedge clk);
    awid = v.id; awaddr = v.addr[AW-1:0]; awlen = v.len[7:0];
    awsize = v.size; awburst = v.burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_to_w_latency", wready, 1'b1);
    for (int i = 0; i <= v.len; i++) begin
      d = v.base + 32'(i);
      wvalid = 1'b1; wdata = d; wstrb = v.strb; wlast = (i == v.len);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) chk("w_accept", wready, 1'b1);
      @(posedge clk);
      if (ok) begin
        w = ((v.addr >> 2) + i) % 256;
        for (int b = 0; b < BY; b++)
          if (v.strb[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int k = 0; k < v.bhold; k++) begin
      chk("bvalid_hold", bvalid, 1'b1);
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", bvalid, 1'b1);
    chk("bid", bid, v.id);
    chk("bresp", bresp, v.exp_b);
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input int addr, input int len,
                         input logic [2:0] size, input logic [1:0] exp_r,
                         input int stall_beat, input int stall_cyc,
                         input logic cflag, input logic [DW-1:0] cval);
    rexp_t e;
    int n;
    int beats;
    logic stalled;
    logic [DW-1:0] held;
    for (int i = 0; i <= len; i++) begin
      if (size != 3'd2)  e.data = '0;
      else if (cflag)    e.data = cval;
      else               e.data = model[((addr >> 2) + i) % 256];
      e.last = (i == len); e.resp = exp_r; e.id = id;
      sb.push_back(e);
    end
    @(negedge clk);
    arid = id; araddr = addr[AW-1:0]; arlen = len[7:0];
    arsize = size; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_accept", arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    chk("ar_to_r_latency", rvalid, 1'b1);
    beats = 0; n = 0; stalled = 1'b0;
    while (beats <= len && n < 1000) begin
      if (rvalid && beats == stall_beat && !stalled) begin
        rready = 1'b0; held = rdata; stalled = 1'b1;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          chk("r_stall_valid", rvalid, 1'b1);
          chk("r_stall_data", rdata, held);
        end
        rready = 1'b1;
      end
      if (rvalid) begin
        e = sb.pop_front();
        chk("rdata", rdata, e.data);
        chk("rlast", rlast, e.last);
        chk("rresp", rresp, e.resp);
        chk("rid", rid, e.id);
        beats++;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    chk("r_beat_count", beats, len + 1);
    chk("rvalid_after_last", rvalid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd1, 'h010, 3,   2'b01, 3'd2, 4'hF, 32'h0000_00A0, 0, 2'b00, 1'b1, 3,   3'd2, 2'b00, -1, 0, 1'b0, 32'h0};
    vecs[1] = '{8'd2, 'h010, 3,   2'b00, 3'd2, 4'hF, 32'h0000_EE00, 0, 2'b10, 1'b1, 3,   3'd2, 2'b00, -1, 0, 1'b0, 32'h0};
    vecs[2] = '{8'd3, 'h030, 1,   2'b01, 3'd2, 4'hF, 32'h0000_00C0, 0, 2'b00, 1'b1, 1,   3'd0, 2'b10, -1, 0, 1'b0, 32'h0};
    vecs[3] = '{8'd5, 'h3F8, 3,   2'b01, 3'd2, 4'hF, 32'h5500_0000, 0, 2'b00, 1'b1, 3,   3'd2, 2'b00, -1, 0, 1'b0, 32'h0};
    vecs[4] = '{8'd6, 'h100, 7,   2'b01, 3'd2, 4'hF, 32'h0000_00B0, 5, 2'b00, 1'b1, 7,   3'd2, 2'b00, 2,  3, 1'b0, 32'h0};
    vecs[5] = '{8'd7, 'h020, 0,   2'b01, 3'd2, 4'hF, 32'hFFFF_FFFF, 0, 2'b00, 1'b0, 0,   3'd2, 2'b00, -1, 0, 1'b0, 32'h0};
    vecs[6] = '{8'd8, 'h020, 0,   2'b01, 3'd2, 4'h5, 32'h1234_5678, 0, 2'b00, 1'b1, 0,   3'd2, 2'b00, -1, 0, 1'b1, 32'hFF34_FF78};
    vecs[7] = '{8'd4, 'h000, 255, 2'b01, 3'd2, 4'hF, 32'h0000_0000, 0, 2'b00, 1'b1, 255, 3'd2, 2'b00, -1, 0, 1'b0, 32'h0};

    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_bid_bresp", {bid, bresp}, '0);
    chk("rst_rid_rresp", {rid, rresp}, '0);
    chk("rst_rdata", rdata, 32'h0);

    for (int t = 0; t < 8; t++) begin
      do_write(vecs[t]);
      if (vecs[t].rd)
        do_read(vecs[t].id, vecs[t].addr, vecs[t].rd_len, vecs[t].rd_size, vecs[t].exp_r,
                vecs[t].stall_beat, vecs[t].stall_cyc, vecs[t].cflag, vecs[t].cval);
    end

    // 0x400 does not fit the 10-bit address, so this 44-beat read restarts at word 0
    do_read(8'd10, 'h400, 43, 3'd2, 2'b00, -1, 0, 1'b0, 32'h0);

    // Reset in the middle of a 4-beat write after two accepted beats
    @(negedge clk);
    chk("mid_rst_awready", awready, 1'b1);
    awid = 8'd9; awaddr = 10'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_wready", wready, 1'b1);
      wvalid = 1'b1; wdata = 32'hD0D0_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
      @(posedge clk);
      model[128 + i] = 32'hD0D0_0000 + 32'(i);
      @(negedge clk);
    end
    wvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready", wready, 1'b0);
    chk("post_rst_bvalid", bvalid, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_no_b", bvalid, 1'b0);
    do_read(8'd11, 'h200, 1, 3'd2, 2'b00, -1, 0, 1'b0, 32'h0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_slave_ram.md
Name: axi4_slave_ram

Overview:
- AXI4 slave memory used as the target of the team's master AXI4 test interface.
- Independent read and write channels access a shared word-addressed register array. Each channel accepts one burst at a time.
- Supports INCR bursts of 1..256 beats with full-bus-width beats.
- Used in simulation and unit test benches to close the loop on master read/write burst and transaction tasks.

Parameters:
- AXI4_DATA_W, 32, data bus width in bits (multiple of 8).
- AXI4_ADD_W, 10, byte address width.
- AXI4_ID_W, 8, transaction ID width.
- Derived localparam BYTES = AXI4_DATA_W/8; BYTES_W = clog2(BYTES).
- Derived localparam DEPTH = 2**(AXI4_ADD_W-BYTES_W) words.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADD_W/8/3/2  write address.
- awvalid in 1; awready out 1.
- wdata/wstrb/wlast  in  DATA_W/BYTES/1  write data.
- wvalid in 1; wready out 1.
- bid/bresp  out  ID_W/2  write response.
- bvalid out 1; bready in 1.
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADD_W/8/3/2  read address.
- arvalid in 1; arready out 1.
- rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data.
- rvalid out 1; rready in 1.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0. Memory contents are not reset.
- Reset asserted mid-burst: both FSMs return to IDLE; partially written words keep their data; no response is issued.
- Write FSM states WIDLE -> WDATA -> WRESP -> WIDLE.
- WIDLE: awready=1. On awvalid&awready, register id, word address (awaddr>>BYTES_W), len and error flag, then go to WDATA.
- Write error flag: set when awburst != 2'b01 or awsize != BYTES_W.
- WDATA: wready=1. Each wvalid&wready beat writes the bytes enabled by wstrb at the current word, unless the error flag is set. Word address then increments modulo DEPTH (wrap-around, no boundary check).
- W beats presented before the AW handshake are stalled (wready=0 in WIDLE).
- Leaving WDATA: on the beat with wlast=1, go to WRESP. A wlast/len mismatch sets the error flag; the FSM still exits on wlast.
- WRESP: bvalid=1, bid = captured id, bresp = 2'b10 (SLVERR) on error, else 2'b00. Hold until bready; then go to WIDLE with awready=1 next cycle.
- Read FSM states RIDLE -> RDATA -> RIDLE.
- RIDLE: arready=1. On handshake, capture id, word address, len and error flag (same rule as write), and clear beat count. First rvalid appears the next cycle.
- RDATA: rvalid=1; rdata = mem[current word], combinational from the array, or 0 when the error flag is set; rid = captured id; rresp = SLVERR/OKAY.
- rlast=1 when beat count == len. Each rvalid&rready advances the beat count and the word address (modulo DEPTH).
- rvalid and all R payload stay stable while rready=0.
- Ending a read burst: handshake with rlast -> RIDLE; rvalid=0 next cycle.
- Read/write concurrency: channels are fully independent. A read of a word written on the same edge returns the pre-write value.
- Throughput: 1 beat/cycle under continuous valid/ready. AW-to-first-W acceptance takes 1 cycle; AR-to-first-R takes 1 cycle.

Decomposition:
- Package axi4_slave_ram_pkg holds: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_BURST_INCR=2'b01, and enums for the write FSM states (WIDLE, WDATA, WRESP) and read FSM states (RIDLE, RDATA).
- One sub-module, axi4_slave_ram_array: byte-enabled register array with one write port and one asynchronous read port, no reset.

Test Plan:
- Single 4-beat write: address 0x010, data {A0,A1,A2,A3}, strobe all ones -> bresp=0, bid=1. A 4-beat read of 0x010 then returns A0..A3, rlast only on beat 4, rresp=0, rid=1.
- Full-space burst (32-bit bus): write 256 beats, data i, from address 0x000. Reading 300 words from 0x000 gives 256 words + 44 words; the second burst's address 0x400 truncates to 0x000 -> data i mod 256.
- Wrap-around: 4-beat write at 0x3F8 -> words land at 0x3F8, 0x3FC, 0x000, 0x004. Reading those addresses confirms the data.
- Partial strobe: write 0xFFFFFFFF to 0x020, then 0x12345678 with wstrb=4'b0101 -> read returns 0xFF34FF78.
- Backpressure: during an 8-beat read, hold rready low 3 cycles on beat 2 -> rdata and rvalid held stable, no beat lost. Hold bready low 5 cycles -> bvalid stays 1.
- Error and reset: awburst=2'b00 -> bresp=2'b10 and memory unchanged. arsize=0 -> rresp=2'b10. Asserting rst_n=0 mid write burst -> awready=1, wready=0, bvalid=0 after release.
